alu_issue_unit: RTL

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_issue_regfile.sv | 47 ++++
 rtl/alu_issue_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue unit:
//   - instruction field positions inside the 13-bit instruction word
//   - opcode constants (ALU ops, LDI, illegal encodings)
//   - issue FSM state type
//   - is_alu_op() helper: true for the opcodes that go through the ALU
// ---------------------------------------------------------------------------
package alu_pkg;

    // Instruction word layout: [12:10] op, [9:8] rd, [7:6] ra, [5:4] rb, [3:0] imm
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 10;
    localparam int RD_MSB  = 9;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_NOT   = 3'b100;
    localparam logic [2:0] OP_LDI   = 3'b101;
    localparam logic [2:0] OP_ILL0  = 3'b110;
    localparam logic [2:0] OP_ILL1  = 3'b111;

    // Opcode driven to the ALU while nothing has been issued yet.
    localparam logic [2:0] OP_RESET = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// ---------------------------------------------------------------------------
// alu_issue_regfile
// 4-entry x 4-bit register file, one synchronous write port and three
// combinational read ports (operand A, operand B, debug).
//
// Parameters:
//   RESET_VAL  value loaded into every entry on rst
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   we, waddr, wdata     write port (write lands on the rising edge)
//   raddr_a / rdata_a    operand A read
//   raddr_b / rdata_b    operand B read
//   raddr_d / rdata_d    debug read
// ---------------------------------------------------------------------------
module alu_issue_regfile #(
    parameter logic [3:0] RESET_VAL = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [3:0] wdata,
    input  logic [1:0] raddr_a,
    output logic [3:0] rdata_a,
    input  logic [1:0] raddr_b,
    output logic [3:0] rdata_b,
    input  logic [1:0] raddr_d,
    output logic [3:0] rdata_d
);

    logic [3:0] regs [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
// Accepts one 13-bit instruction at a time, reads its operands from a
// private 4x4 register file, drives an external combinational ALU, writes
// the result back and presents a response until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its payload until that edge; ready never
// depends combinationally on valid. resp_valid stays high with stable
// response fields until the edge where resp_ready is seen.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   instr_valid/instr_ready/instr   instruction channel
//   alu_a, alu_b, alu_opcode        registered operands/opcode to the ALU
//   alu_result, alu_carry, alu_zero ALU outputs (combinational from above)
//   resp_valid/resp_ready           response channel
//   resp_data, resp_carry,
//   resp_zero, resp_err             response payload
//   dbg_addr / dbg_data             combinational register-file read
//   dbg_state                       current FSM state
//   sticky_carry, sticky_zero       only with ALU_ISSUE_STICKY_FLAGS_EN:
//                                   OR of all ALU-op flags since reset
// ---------------------------------------------------------------------------
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter logic [3:0] RESET_VAL = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [12:0] instr,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_opcode,
    input  logic [3:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [3:0]  resp_data,
    output logic        resp_carry,
    output logic        resp_zero,
    output logic        resp_err,
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    output logic        sticky_carry,
    output logic        sticky_zero,
`endif
    input  logic [1:0]  dbg_addr,
    output logic [3:0]  dbg_data,
    output state_t      dbg_state
);

    state_t     state_q, state_nxt;
    logic       accept;
    logic [2:0] op;
    logic [1:0] rd, ra, rb;
    logic [3:0] imm;
    logic [1:0] rd_q;
    logic [3:0] rdata_a, rdata_b;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata;

    assign op  = instr[OP_MSB:OP_LSB];
    assign rd  = instr[RD_MSB:RD_LSB];
    assign ra  = instr[RA_MSB:RA_LSB];
    assign rb  = instr[RB_MSB:RB_LSB];
    assign imm = instr[IMM_MSB:IMM_LSB];

    assign accept    = instr_valid && instr_ready;
    assign dbg_state = state_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt   = state_q;
        instr_ready = 1'b0;
        resp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = is_alu_op(op) ? ST_EXEC : ST_WB;
            end
            ST_EXEC: state_nxt = ST_WB;
            ST_WB: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- register file ----------------
    // LDI writes at its accept edge; ALU ops write at the end of EXEC.
    // The two can never coincide because accept only happens in IDLE.
    // rst has priority inside the register file, so an instruction caught
    // by reset never writes.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = imm;
        if (state_q == ST_EXEC) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = alu_result;
        end else if (accept && op == OP_LDI) begin
            rf_we = 1'b1;
        end
    end

    alu_issue_regfile #(
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ra),
        .rdata_a (rdata_a),
        .raddr_b (rb),
        .rdata_b (rdata_b),
        .raddr_d (dbg_addr),
        .rdata_d (dbg_data)
    );

    // ---------------- datapath ----------------
    // Operands are captured at accept, so rd==ra/rb sees pre-write values.
    // ALU operand registers only move on an ALU-op accept and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= 4'h0;
            alu_b      <= 4'h0;
            alu_opcode <= OP_RESET;
            rd_q       <= 2'd0;
            resp_data  <= 4'h0;
            resp_carry <= 1'b0;
            resp_zero  <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                if (is_alu_op(op)) begin
                    alu_a      <= rdata_a;
                    alu_b      <= rdata_b;
                    alu_opcode <= op;
                    rd_q       <= rd;
                end else if (op == OP_LDI) begin
                    resp_data  <= imm;
                    resp_carry <= 1'b0;
                    resp_zero  <= (imm == 4'h0);
                    resp_err   <= 1'b0;
                end else begin
                    resp_data  <= 4'h0;
                    resp_carry <= 1'b0;
                    resp_zero  <= 1'b0;
                    resp_err   <= 1'b1;
                end
            end
            if (state_q == ST_EXEC) begin
                resp_data  <= alu_result;
                resp_carry <= alu_carry;
                resp_zero  <= alu_zero;
                resp_err   <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    // Accumulates flags of every ALU-op write; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_carry <= 1'b0;
            sticky_zero  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            sticky_carry <= sticky_carry | alu_carry;
            sticky_zero  <= sticky_zero  | alu_zero;
        end
    end
`endif

endmodule
